// File: rtl/line_pkg.sv
// Shared types and width constants for the Bresenham line rasteriser.
// DW holds |dx| or -|dy|. EW holds err, which can reach dx+dy and their doubles' neighbourhood.
package line_pkg;

  localparam int COORD_W_DEF = 8;
  localparam int DW          = COORD_W_DEF + 1;
  localparam int EW          = COORD_W_DEF + 2;

  typedef enum logic {
    IDLE = 1'b0,
    PLOT = 1'b1
  } state_t;

endpackage

// File: rtl/line_drawer_if.sv
// Request/pixel bundle between a line client (master) and the line rasteriser (slave).
interface line_drawer_if
  import line_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);

  logic               start;
  logic               abort;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               busy;
  logic               plot_valid;
  logic               plot_ready;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               done;
  logic [COORD_W:0]   plot_count;

  modport master (
    output start, abort, x0, y0, x1, y1, plot_ready,
    input  busy, plot_valid, x, y, done, plot_count
  );

  modport slave (
    input  start, abort, x0, y0, x1, y1, plot_ready,
    output busy, plot_valid, x, y, done, plot_count
  );

endinterface

// File: rtl/line_drawer_step.sv
// One combinational Bresenham step: the next error term and pixel from the current ones.
// The x and y updates both use the incoming err, so a diagonal move happens in one step.
module line_step
  import line_pkg::*;
#(
  parameter int CW  = COORD_W_DEF,
  parameter int DXW = DW,
  parameter int EXW = EW
) (
  input  logic signed [EXW-1:0] err,
  input  logic signed [DXW-1:0] dx,
  input  logic signed [DXW-1:0] dy,
  input  logic        [CW-1:0]  x,
  input  logic        [CW-1:0]  y,
  input  logic                  sx_neg,
  input  logic                  sy_neg,
  output logic signed [EXW-1:0] err_next,
  output logic        [CW-1:0]  x_next,
  output logic        [CW-1:0]  y_next
);

  localparam logic [CW-1:0] ONE = 1;

  logic signed [EXW:0] e2;
  logic                step_x;
  logic                step_y;

  always_comb begin
    e2       = {err, 1'b0};
    step_x   = (e2 >= (EXW+1)'(dy));
    step_y   = (e2 <= (EXW+1)'(dx));
    err_next = err;
    x_next   = x;
    y_next   = y;
    if (step_x) begin
      err_next = err_next + EXW'(dy);
      x_next   = sx_neg ? (x - ONE) : (x + ONE);
    end
    if (step_y) begin
      err_next = err_next + EXW'(dx);
      y_next   = sy_neg ? (y - ONE) : (y + ONE);
    end
  end

endmodule

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: latches two endpoints and emits one pixel per accepted
// valid/ready transfer, with abort, a fired-pixel counter and a one-cycle done pulse.
module line_drawer
  import line_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input logic         clk,
  input logic         reset,
  line_drawer_if.slave bus
);

  localparam int DXW = COORD_W + 1;
  localparam int EXW = COORD_W + 2;
  localparam logic [COORD_W:0] CNT_ONE = 1;

  state_t                    state_q, state_d;
  logic signed [DXW-1:0]     dx_q, dx_d, dy_q, dy_d;
  logic signed [EXW-1:0]     err_q, err_d, err_step;
  logic                      sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic        [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic        [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic        [COORD_W-1:0] x_step, y_step, adx, ady;
  logic        [COORD_W:0]   count_q, count_d;
  logic                      done_q, done_d;
  logic                      fire;

  line_step #(
    .CW  (COORD_W),
    .DXW (DXW),
    .EXW (EXW)
  ) u_step (
    .err      (err_q),
    .dx       (dx_q),
    .dy       (dy_q),
    .x        (x_q),
    .y        (y_q),
    .sx_neg   (sx_neg_q),
    .sy_neg   (sy_neg_q),
    .err_next (err_step),
    .x_next   (x_step),
    .y_next   (y_step)
  );

  always_comb begin
    adx      = (bus.x0 < bus.x1) ? (bus.x1 - bus.x0) : (bus.x0 - bus.x1);
    ady      = (bus.y0 < bus.y1) ? (bus.y1 - bus.y0) : (bus.y0 - bus.y1);
    fire     = (state_q == PLOT) && bus.plot_ready;
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    count_d  = count_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = PLOT;
          dx_d     = $signed({1'b0, adx});
          dy_d     = -$signed({1'b0, ady});
          err_d    = EXW'(dx_d) + EXW'(dy_d);
          sx_neg_d = !(bus.x0 < bus.x1);
          sy_neg_d = !(bus.y0 < bus.y1);
          x_d      = bus.x0;
          y_d      = bus.y0;
          x1_d     = bus.x1;
          y1_d     = bus.y1;
          count_d  = '0;
        end
      end
      PLOT: begin
        if (fire) begin
          count_d = count_q + CNT_ONE;
        end
        // Abort takes priority even over the final fire, which suppresses done.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (fire) begin
          if ((x_q == x1_q) && (y_q == y1_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            err_d = err_step;
            x_d   = x_step;
            y_d   = y_step;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = (state_q == PLOT);
  assign bus.plot_valid = (state_q == PLOT);
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.done       = done_q;
  assign bus.plot_count = count_q;

endmodule
